// File: rtl/ascon_ctrl_fsm.sv
// Sequencing controller for the ASCON-128 encryption datapath: steps the shared
// round counter and permutation/XOR controls through init, AD, plaintext and final.
module ascon_ctrl_fsm (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [2:0] ad_blocks_i,
  input  logic [2:0] pt_blocks_i,
  input  logic       data_valid_i,
  input  logic [3:0] cpt_i,
  output logic       data_ready_o,
  output logic       en_round_o,
  output logic       init_a_o,
  output logic       init_b_o,
  output logic       en_reg_state_o,
  output logic       input_select_o,
  output logic       xor_data_o,
  output logic       xor_key_begin_o,
  output logic       xor_key_end_o,
  output logic       xor_lsb_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  // Handshake: a block transfers in exactly the cycle where data_ready_o and
  // data_valid_i are both high; data_ready_o only rises in the WAIT states and
  // may stay high indefinitely, data_valid_i is ignored everywhere else.

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INIT_CONF = 4'd1,
    INIT_RND  = 4'd2,
    AD_WAIT   = 4'd3,
    AD_RND    = 4'd4,
    PT_WAIT   = 4'd5,
    PT_RND    = 4'd6,
    FIN_RND   = 4'd7,
    DONE      = 4'd8
  } state_t;

  state_t     state, state_n;
  logic [2:0] ad_left, ad_left_n;
  logic [2:0] pt_left, pt_left_n;

  logic last_rnd;
  logic first_pb;
  assign last_rnd = (cpt_i == 4'd11);
  assign first_pb = (cpt_i == 4'd6);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state   <= IDLE;
      ad_left <= 3'd0;
      pt_left <= 3'd0;
    end else begin
      state   <= state_n;
      ad_left <= ad_left_n;
      pt_left <= pt_left_n;
    end
  end

  always_comb begin
    state_n         = state;
    ad_left_n       = ad_left;
    pt_left_n       = pt_left;
    data_ready_o    = 1'b0;
    en_round_o      = 1'b0;
    init_a_o        = 1'b0;
    init_b_o        = 1'b0;
    en_reg_state_o  = 1'b0;
    input_select_o  = 1'b0;
    xor_data_o      = 1'b0;
    xor_key_begin_o = 1'b0;
    xor_key_end_o   = 1'b0;
    xor_lsb_o       = 1'b0;
    cipher_valid_o  = 1'b0;
    tag_valid_o     = 1'b0;
    busy_o          = (state != IDLE);

    unique case (state)
      IDLE: begin
        if (start_i) begin
          ad_left_n = ad_blocks_i;
          pt_left_n = (pt_blocks_i == 3'd0) ? 3'd1 : pt_blocks_i;
          state_n   = INIT_CONF;
        end
      end
      INIT_CONF: begin
        en_round_o = 1'b1;
        init_a_o   = 1'b1;
        state_n    = INIT_RND;
      end
      INIT_RND: begin
        en_round_o     = 1'b1;
        en_reg_state_o = 1'b1;
        input_select_o = (cpt_i != 4'd0);
        if (last_rnd) begin
          xor_key_end_o = 1'b1;
          if (ad_left == 3'd0) begin
            xor_lsb_o = 1'b1;
            state_n   = PT_WAIT;
          end else begin
            state_n = AD_WAIT;
          end
        end
      end
      AD_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_round_o = 1'b1;
          init_b_o   = 1'b1;
          state_n    = AD_RND;
        end
      end
      AD_RND: begin
        en_round_o     = 1'b1;
        en_reg_state_o = 1'b1;
        input_select_o = 1'b1;
        xor_data_o     = first_pb;
        if (last_rnd) begin
          ad_left_n = ad_left - 3'd1;
          if (ad_left == 3'd1) begin
            xor_lsb_o = 1'b1;
            state_n   = PT_WAIT;
          end else begin
            state_n = AD_WAIT;
          end
        end
      end
      PT_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_round_o = 1'b1;
          // The last plaintext block runs the 12-round finalization directly.
          if (pt_left > 3'd1) begin
            init_b_o = 1'b1;
            state_n  = PT_RND;
          end else begin
            init_a_o = 1'b1;
            state_n  = FIN_RND;
          end
        end
      end
      PT_RND: begin
        en_round_o     = 1'b1;
        en_reg_state_o = 1'b1;
        input_select_o = 1'b1;
        if (first_pb) begin
          xor_data_o     = 1'b1;
          cipher_valid_o = 1'b1;
        end
        if (last_rnd) begin
          pt_left_n = pt_left - 3'd1;
          state_n   = PT_WAIT;
        end
      end
      FIN_RND: begin
        en_round_o     = 1'b1;
        en_reg_state_o = 1'b1;
        input_select_o = 1'b1;
        if (cpt_i == 4'd0) begin
          xor_data_o      = 1'b1;
          xor_key_begin_o = 1'b1;
          cipher_valid_o  = 1'b1;
        end
        if (last_rnd) begin
          xor_key_end_o = 1'b1;
          state_n       = DONE;
        end
      end
      DONE: begin
        tag_valid_o = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Directed bench for ascon_ctrl_fsm: models the external round counter and checks
// per-cycle output traces (bit k = cycle k after the start sampling edge).
module tb_ascon_ctrl_fsm;

  logic       clock_i = 1'b0;
  logic       resetb_i = 1'b0;
  logic       start_i = 1'b0;
  logic [2:0] ad_blocks_i = 3'd0;
  logic [2:0] pt_blocks_i = 3'd0;
  logic       data_valid_i = 1'b0;
  logic [3:0] cpt;
  logic       data_ready_o, en_round_o, init_a_o, init_b_o, en_reg_state_o;
  logic       input_select_o, xor_data_o, xor_key_begin_o, xor_key_end_o;
  logic       xor_lsb_o, cipher_valid_o, tag_valid_o, busy_o;

  int n_cmp = 0;
  int n_err = 0;
  int wrap_err;

  logic [127:0] t_cv, t_tv, t_ia, t_ib, t_xke, t_xlsb, t_xd, t_xkb;
  logic [127:0] t_ers, t_isel, t_dr, t_en, t_busy;
  logic [127:0] e_cv, e_tv, e_ia, e_ib, e_xke, e_xlsb, e_xd, e_xkb;
  logic [127:0] e_ers, e_isel, e_dr, e_en, e_busy;
  logic [12:0]  all_outs;

  assign all_outs = {data_ready_o, en_round_o, init_a_o, init_b_o, en_reg_state_o,
                     input_select_o, xor_data_o, xor_key_begin_o, xor_key_end_o,
                     xor_lsb_o, cipher_valid_o, tag_valid_o, busy_o};

  ascon_ctrl_fsm dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i),
    .ad_blocks_i(ad_blocks_i), .pt_blocks_i(pt_blocks_i),
    .data_valid_i(data_valid_i), .cpt_i(cpt),
    .data_ready_o(data_ready_o), .en_round_o(en_round_o), .init_a_o(init_a_o),
    .init_b_o(init_b_o), .en_reg_state_o(en_reg_state_o),
    .input_select_o(input_select_o), .xor_data_o(xor_data_o),
    .xor_key_begin_o(xor_key_begin_o), .xor_key_end_o(xor_key_end_o),
    .xor_lsb_o(xor_lsb_o), .cipher_valid_o(cipher_valid_o),
    .tag_valid_o(tag_valid_o), .busy_o(busy_o)
  );

  // clock / reset
  always #5 clock_i = ~clock_i;

  // external round counter
  always @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i)        cpt <= 4'd0;
    else if (init_a_o)    cpt <= 4'd0;
    else if (init_b_o)    cpt <= 4'd6;
    else if (en_round_o)  cpt <= cpt + 4'd1;
  end

  function automatic logic [127:0] m(input int a, input int b);
    logic [127:0] r;
    r = '0;
    for (int i = a; i <= b; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic check_m(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver: start one encryption, then drive dv/start per cycle and record traces
  task automatic run(input logic [2:0] ad, input logic [2:0] pt,
                     input logic [127:0] dv_m, input logic [127:0] st_m, input int ncyc);
    t_cv = '0; t_tv = '0; t_ia = '0; t_ib = '0; t_xke = '0; t_xlsb = '0; t_xd = '0;
    t_xkb = '0; t_ers = '0; t_isel = '0; t_dr = '0; t_en = '0; t_busy = '0;
    wrap_err = 0;
    ad_blocks_i = ad; pt_blocks_i = pt; start_i = 1'b1; data_valid_i = 1'b0;
    @(posedge clock_i);
    #1 start_i = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock_i);
      data_valid_i = dv_m[k];
      start_i = st_m[k];
      #1;
      t_cv[k] = cipher_valid_o;   t_tv[k] = tag_valid_o;     t_ia[k] = init_a_o;
      t_ib[k] = init_b_o;         t_xke[k] = xor_key_end_o;  t_xlsb[k] = xor_lsb_o;
      t_xd[k] = xor_data_o;       t_xkb[k] = xor_key_begin_o; t_ers[k] = en_reg_state_o;
      t_isel[k] = input_select_o; t_dr[k] = data_ready_o;    t_en[k] = en_round_o;
      t_busy[k] = busy_o;
      if (en_round_o && !init_a_o && !init_b_o && cpt > 4'd11) wrap_err++;
    end
    data_valid_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic check_traces(input string p);
    check_m({p, "_cipher_valid"}, t_cv, e_cv);
    check_m({p, "_tag_valid"}, t_tv, e_tv);
    check_m({p, "_init_a"}, t_ia, e_ia);
    check_m({p, "_init_b"}, t_ib, e_ib);
    check_m({p, "_xor_key_end"}, t_xke, e_xke);
    check_m({p, "_xor_lsb"}, t_xlsb, e_xlsb);
    check_m({p, "_xor_data"}, t_xd, e_xd);
    check_m({p, "_xor_key_begin"}, t_xkb, e_xkb);
    check_m({p, "_en_reg_state"}, t_ers, e_ers);
    check_m({p, "_input_select"}, t_isel, e_isel);
    check_m({p, "_data_ready"}, t_dr, e_dr);
    check_m({p, "_en_round"}, t_en, e_en);
    check_m({p, "_busy"}, t_busy, e_busy);
    check_i({p, "_cnt_wrap"}, wrap_err, 0);
  endtask

  task automatic exp_ad1_pt4();
    e_cv = m(22,22) | m(29,29) | m(36,36) | m(43,43);
    e_tv = m(55,55);
    e_ia = m(1,1) | m(42,42);
    e_ib = m(14,14) | m(21,21) | m(28,28) | m(35,35);
    e_xke = m(13,13) | m(54,54);
    e_xlsb = m(20,20);
    e_xd = m(15,15) | m(22,22) | m(29,29) | m(36,36) | m(43,43);
    e_xkb = m(43,43);
    e_ers = m(2,13) | m(15,20) | m(22,27) | m(29,34) | m(36,41) | m(43,54);
    e_isel = e_ers & ~m(2,2);
    e_dr = m(14,14) | m(21,21) | m(28,28) | m(35,35) | m(42,42);
    e_en = m(1,54);
    e_busy = m(1,55);
  endtask

  task automatic exp_ad0_pt1();
    e_cv = m(15,15); e_tv = m(27,27); e_ia = m(1,1) | m(14,14); e_ib = '0;
    e_xke = m(13,13) | m(26,26); e_xlsb = m(13,13); e_xd = m(15,15); e_xkb = m(15,15);
    e_ers = m(2,13) | m(15,26); e_isel = e_ers & ~m(2,2); e_dr = m(14,14);
    e_en = m(1,26); e_busy = m(1,27);
  endtask

  initial begin
    // reset state
    #2;
    check_m("reset_outputs", {115'd0, all_outs}, 128'd0);
    #20;
    @(negedge clock_i);
    resetb_i = 1'b1;
    @(negedge clock_i);
    #1 check_m("post_reset_idle", {115'd0, all_outs}, 128'd0);

    // ad=1 pt=4, data always valid
    run(3'd1, 3'd4, '1, '0, 60);
    exp_ad1_pt4();
    check_traces("t1");

    // ad=0 pt=1: init goes straight to the final block
    run(3'd0, 3'd1, '1, '0, 30);
    exp_ad0_pt1();
    check_traces("t2");

    // ad=1 pt=1 with data_valid low for cycles 14..18
    run(3'd1, 3'd1, ~m(14,18), '0, 45);
    e_cv = m(27,27); e_tv = m(39,39); e_ia = m(1,1) | m(26,26); e_ib = m(19,19);
    e_xke = m(13,13) | m(38,38); e_xlsb = m(25,25); e_xd = m(20,20) | m(27,27);
    e_xkb = m(27,27); e_ers = m(2,13) | m(20,25) | m(27,38); e_isel = e_ers & ~m(2,2);
    e_dr = m(14,19) | m(26,26); e_en = m(1,13) | m(19,38); e_busy = m(1,39);
    check_traces("t3");

    // start_i pulsed while busy must not disturb the ad=1 pt=4 timing
    run(3'd1, 3'd4, '1, m(5,5) | m(30,30) | m(50,50) | m(55,55), 60);
    exp_ad1_pt4();
    check_traces("t4");

    // ad=7 pt=0 (treated as 1)
    run(3'd7, 3'd0, '1, '0, 80);
    e_ib = '0; e_xd = m(64,64); e_dr = m(63,63); e_ers = m(2,13) | m(64,75);
    for (int i = 0; i < 7; i++) begin
      e_ib |= m(14 + 7*i, 14 + 7*i);
      e_dr |= m(14 + 7*i, 14 + 7*i);
      e_xd |= m(15 + 7*i, 15 + 7*i);
      e_ers |= m(15 + 7*i, 20 + 7*i);
    end
    e_cv = m(64,64); e_tv = m(76,76); e_ia = m(1,1) | m(63,63);
    e_xke = m(13,13) | m(75,75); e_xlsb = m(62,62); e_xkb = m(64,64);
    e_isel = e_ers & ~m(2,2); e_en = m(1,75); e_busy = m(1,76);
    check_traces("t5");

    // reset mid-FIN_RND aborts immediately, no tag afterwards
    run(3'd0, 3'd1, '1, '0, 20);
    check_i("t6_in_fin_busy", int'(busy_o), 1);
    resetb_i = 1'b0;
    #1 check_m("t6_reset_outputs", {115'd0, all_outs}, 128'd0);
    @(negedge clock_i);
    resetb_i = 1'b1;
    t_tv = '0; t_busy = '0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock_i);
      #1;
      t_tv[k] = tag_valid_o;
      t_busy[k] = busy_o;
    end
    check_m("t6_no_tag", t_tv, 128'd0);
    check_m("t6_idle_busy", t_busy, 128'd0);

    // normal run after the abort
    run(3'd0, 3'd1, '1, '0, 30);
    exp_ad0_pt1();
    check_traces("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ascon_ctrl_fsm.md
# ascon_ctrl_fsm

Sequencing controller for the ASCON-128 encryption datapath. It drives the shared round counter (en_round/init_a/init_b) and the permutation/XOR datapath through initialization, associated data, plaintext and finalization. Blocks are exchanged with the upstream source through a ready/valid handshake. Cipher and tag strobes go to the output stage.

## Interface
- No parameters.
- clock_i  in  1  system clock
- resetb_i  in  1  reset, asynchronous, active-low
- start_i  in  1  start one encryption; sampled only in IDLE
- ad_blocks_i  in  3  number of 64-bit AD blocks (0..7); latched on accepted start
- pt_blocks_i  in  3  number of plaintext blocks (1..7; 0 treated as 1); latched on accepted start
- data_valid_i  in  1  upstream block available
- cpt_i  in  4  round counter value (loads 0 on init_a, 6 on init_b, else +1 when enabled)
- data_ready_o  out  1  controller waiting for a block
- en_round_o  out  1  round counter enable
- init_a_o  out  1  counter load 0 (12-round pa)
- init_b_o  out  1  counter load 6 (6-round pb)
- en_reg_state_o  out  1  state register load
- input_select_o  out  1  0: permutation input = initial state; 1: state register feedback
- xor_data_o  out  1  XOR data block into rate at permutation input
- xor_key_begin_o  out  1  XOR key into capacity at permutation input
- xor_key_end_o  out  1  XOR key into capacity at permutation output
- xor_lsb_o  out  1  XOR domain-separation bit 0x1 at permutation output
- cipher_valid_o  out  1  ciphertext block valid, 1-cycle pulse
- tag_valid_o  out  1  tag valid, 1-cycle pulse
- busy_o  out  1  high outside IDLE

## Operation
- States: IDLE, INIT_CONF, INIT_RND, AD_WAIT, AD_RND, PT_WAIT, PT_RND, FIN_RND, DONE. Internal counters ad_left (3 b) and pt_left (3 b).
- All outputs are decoded combinationally from state, cpt_i, data_valid_i and the block counters. Unlisted outputs are 0.
- IDLE: on start_i, latch the counts and go to INIT_CONF.
- INIT_CONF: en_round=1, init_a=1. Go to INIT_RND.
- INIT_RND: en_round=1, en_reg_state=1. input_select=0 when cpt_i==0, else 1.
  - At cpt_i==11: xor_key_end=1.
  - If ad_left==0: xor_lsb=1, go to PT_WAIT. Else go to AD_WAIT.
- AD_WAIT: data_ready=1. On data_valid_i: en_round=1, init_b=1, go to AD_RND.
- AD_RND: en_round=1, en_reg_state=1, input_select=1, xor_data=1 when cpt_i==6.
  - At cpt_i==11: ad_left--.
  - If this was the last AD block: xor_lsb=1, go to PT_WAIT. Else go to AD_WAIT.
- PT_WAIT: data_ready=1. On data_valid_i:
  - pt_left>1: en_round=1, init_b=1, go to PT_RND.
  - pt_left==1: en_round=1, init_a=1, go to FIN_RND.
- PT_RND: en_round=1, en_reg_state=1, input_select=1.
  - cpt_i==6: xor_data=1, cipher_valid=1.
  - cpt_i==11: pt_left--, go to PT_WAIT.
- FIN_RND: en_round=1, en_reg_state=1, input_select=1.
  - cpt_i==0: xor_data=1, xor_key_begin=1, cipher_valid=1.
  - cpt_i==11: xor_key_end=1, go to DONE.
- DONE: tag_valid=1 for one cycle, then IDLE.
- start_i is ignored when busy. data_valid_i is ignored outside the WAIT states. A block is consumed only in a cycle with data_ready_o & data_valid_i.

## Timing
- Reset: state=IDLE and block counters=0. All outputs 0, including busy_o and data_ready_o. Reset asserted mid-operation aborts immediately with no tag pulse.
- Round-end transitions are keyed on cpt_i==11. The controller never lets the counter wrap past 11 while en_round_o=1.
- Handshake: the accept cycle is also the counter load cycle, so each block costs 1 accept cycle plus its rounds.
  - pb block: 6 round cycles.
  - Final block: 12 round cycles.
  - Initialization: 1 + 12 cycles.
- data_ready_o may stay high indefinitely. Outputs hold 0 while waiting.
- Minimum latency, from the start_i sampling edge with data_valid_i held high, ad=1, pt=4:
  - Cycle 1: INIT_CONF.
  - Cycles 2–13: INIT_RND.
  - Cycle 14: AD accept; cycles 15–20: AD rounds.
  - PT accepts at cycles 21, 28, 35; cipher_valid at 22, 29, 36.
  - Cycle 42: final accept; cipher_valid at 43.
  - Cycle 54: xor_key_end; cycle 55: tag_valid.

## Test plan
- Reset mid-FIN_RND: deassert resetb_i → all outputs 0 immediately. After release, state=IDLE and busy_o=0.
- ad=1, pt=4, data_valid_i always high → cipher_valid at cycles 22/29/36/43, tag_valid at cycle 55. init_a_o=1 exactly at cycles 1 and 42; init_b_o=1 at 14/21/28/35.
- ad=0, pt=1 → xor_key_end and xor_lsb both high on the last INIT_RND cycle (cpt_i==11), followed by PT_WAIT. Next: accept with init_a, then 12 rounds, then tag_valid.
- Stall: data_valid_i low for 5 cycles in AD_WAIT → data_ready_o stays high, en_round_o/en_reg_state_o stay 0. The accept then proceeds normally.
- start_i pulsed while busy, and data_valid_i high during rounds → no effect; sequence timing is identical to the undisturbed run.
- pt_blocks_i=0 and ad_blocks_i=7 → 7 AD blocks with xor_lsb only on the 7th. Exactly one cipher_valid pulse, then tag_valid.
